// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC select encoding.
package pc_pkg;

   typedef logic [1:0] pc_sel_t;

   localparam pc_sel_t PC_SEL_INC = 2'b00;
   localparam pc_sel_t PC_SEL_ALU = 2'b01;
   localparam pc_sel_t PC_SEL_JMP = 2'b10;
   localparam pc_sel_t PC_SEL_RET = 2'b11;

endpackage

// File: rtl/pc_unit_if.sv
// Control-unit <-> PC-unit bundle: select/targets in, fetch address and RAS status out.
interface pc_unit_if #(
   parameter int unsigned WIDTH = 32
);
   import pc_pkg::*;

   logic             en;
   pc_sel_t          S_MXPC;
   logic             call;
   logic [WIDTH-1:0] in_ALU;
   logic [WIDTH-1:0] in_JMP;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] pc_next;
   logic             ras_empty;
   logic             ras_full;
   logic             ras_underflow;

   modport master (
      output en, S_MXPC, call, in_ALU, in_JMP,
      input  pc, pc_next, ras_empty, ras_full, ras_underflow
   );

   modport slave (
      input  en, S_MXPC, call, in_ALU, in_JMP,
      output pc, pc_next, ras_empty, ras_full, ras_underflow
   );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack: a push on a full stack silently replaces the oldest entry.
module ras_stack #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top,
   output logic             empty,
   output logic             full,
   output logic             underflow
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  ptr_q, ptr_d, top_idx;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             uf_q, uf_d;

   // ptr_q addresses the next free slot; with a power-of-two depth it wraps onto the oldest.
   always_comb begin
      empty   = (cnt_q == '0);
      full    = (cnt_q == CntW'(DEPTH));
      top_idx = ptr_q - 1'b1;
      top     = mem_q[top_idx];
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      uf_d    = uf_q;
      if (push) begin
         ptr_d = ptr_q + 1'b1;
         if (!full) begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (pop) begin
         if (empty) begin
            uf_d = 1'b1;
         end else begin
            ptr_d = top_idx;
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q <= '0;
         cnt_q <= '0;
         uf_q  <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         uf_q  <= uf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[ptr_q] <= push_data;
      end
   end

   assign underflow = uf_q;

endmodule

// File: rtl/pc_unit.sv
// Program counter with four-way next-PC select, stall and a return-address stack.
module pc_unit
   import pc_pkg::*;
#(
   parameter int unsigned     WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter int unsigned     STEP      = 1,
   parameter int unsigned     RAS_DEPTH = 4
) (
   input logic       clk,
   input logic       rst_n,
   pc_unit_if.slave  bus
);

   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] pc_inc;
   logic [WIDTH-1:0] pc_nxt;
   logic [WIDTH-1:0] ras_top;
   logic             ras_empty;
   logic             ras_full;
   logic             ras_uf;
   logic             push;
   logic             pop;

   assign pc_inc = pc_q + WIDTH'(STEP);

   // A return on an empty stack falls through to the increment.
   always_comb begin
      pc_nxt = pc_inc;
      push   = 1'b0;
      pop    = 1'b0;
      unique case (bus.S_MXPC)
         PC_SEL_INC: pc_nxt = pc_inc;
         PC_SEL_ALU: begin
            pc_nxt = bus.in_ALU;
            push   = bus.en & bus.call;
         end
         PC_SEL_JMP: begin
            pc_nxt = bus.in_JMP;
            push   = bus.en & bus.call;
         end
         PC_SEL_RET: begin
            pc_nxt = ras_empty ? pc_inc : ras_top;
            pop    = bus.en;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else if (bus.en) begin
         pc_q <= pc_nxt;
      end
   end

   ras_stack #(
      .WIDTH (WIDTH),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .push_data (pc_inc),
      .top       (ras_top),
      .empty     (ras_empty),
      .full      (ras_full),
      .underflow (ras_uf)
   );

   assign bus.pc            = pc_q;
   assign bus.pc_next       = pc_nxt;
   assign bus.ras_empty     = ras_empty;
   assign bus.ras_full      = ras_full;
   assign bus.ras_underflow = ras_uf;

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the processor front end. It replaces the two-input next-PC multiplexer with:
- a registered PC;
- a four-way next-PC selector (increment, ALU target, jump target, return);
- a stall/enable input;
- a small hardware return-address stack (RAS) for call/return.

It sits between the control unit and instruction memory and drives the instruction-fetch address every cycle.

## Interface
- `WIDTH`, default 32: PC and target width in bits.
- `RESET_PC`, default 0: PC value loaded on reset.
- `STEP`, default 1: increment per instruction (word-addressed memory).
- `RAS_DEPTH`, default 4: return-stack entries, ≥ 2, power of two.

Ports:
- `clk`  in  1: system clock, rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `en`  in  1: advance PC this cycle; 0 = stall.
- `S_MXPC`  in  2: next-PC select. 00 increment, 01 `in_ALU`, 10 `in_JMP`, 11 return (pop RAS).
- `call`  in  1: with select 01/10, push PC+STEP onto the RAS.
- `in_ALU`  in  WIDTH: branch target computed by the ALU.
- `in_JMP`  in  WIDTH: absolute jump target.
- `pc`  out  WIDTH: current PC (registered).
- `pc_next`  out  WIDTH: value `pc` will take at the next edge if `en`=1 (combinational).
- `ras_empty`  out  1: RAS holds no entries.
- `ras_full`  out  1: RAS holds `RAS_DEPTH` entries.
- `ras_underflow`  out  1: sticky; set by a pop on an empty stack.

## Operation
- **Select decode:**
  - 00 → pc+STEP.
  - 01 → `in_ALU`.
  - 10 → `in_JMP`.
  - 11 → RAS top if not empty, otherwise pc+STEP.
- **Arithmetic:** all additions are modulo 2^WIDTH. All-ones+1 wraps to 0 with no flag.
- **Push:** `en`=1, `call`=1, select 01 or 10.
  - Pushes pc+STEP (the return address) and loads the target.
  - `call` with select 00 or 11 is ignored; no push.
- **Pop:** `en`=1, select 11, stack not empty. Loads the top entry and removes it.
- **Full stack:** a push overwrites the oldest entry (circular buffer). Depth stays `RAS_DEPTH`, `ras_full` stays 1, no error flag.
- **Empty stack:** a pop falls through to pc+STEP, the stack stays empty, and `ras_underflow` is set. It remains set until reset.
- **Stall:** `en`=0 holds `pc` and the RAS and ignores `call`. `pc_next` still reflects the current select.
- **Flags:** `ras_empty` and `ras_full` are derived from a registered count in 0..`RAS_DEPTH`.

## Timing
- **Reset:** `rst_n` is sampled at the rising edge of `clk`. While it is low at an edge, after that edge:
  - `pc` = `RESET_PC`;
  - count = 0, so `ras_empty`=1 and `ras_full`=0;
  - `ras_underflow`=0.
  - Reset overrides `en`, `call` and `S_MXPC` in the same cycle.
  - Reset mid-sequence discards all stack contents.
- **Latency:** one cycle. A select presented in cycle N appears on `pc` after edge N.
- **pc_next:** combinational from `pc`, select, inputs and RAS top. It is valid in the same cycle.
- **Back-to-back calls/returns:** one operation per cycle.
  - A pop in the cycle after a push returns the just-pushed address.
  - No bypass is needed, because the stack updates at the edge.
- **Flag timing:** all flags are registered and update at the same edge as `pc`.

## Structure
- **Package `pc_pkg`:**
  - select encoding constants `PC_SEL_INC`, `PC_SEL_ALU`, `PC_SEL_JMP`, `PC_SEL_RET`;
  - the 2-bit select typedef.
- **Sub-module `ras_stack`**, parameters `WIDTH` and `DEPTH`:
  - inputs: push, pop, push data;
  - outputs: top, empty, full, underflow;
  - circular pointer plus saturating count.
- **`pc_unit`:** holds the PC register, the incrementer and the select mux, and instantiates `ras_stack`.

## Test plan
All cases use WIDTH=32, STEP=1 and RAS_DEPTH=4.
1. **Reset:** `rst_n`=0 for 2 cycles with `en`=1 and select 01 → `pc`=0, `ras_empty`=1, `ras_underflow`=0. Release, select 00 for 3 cycles → `pc`=1, 2, 3.
2. **Wrap and stall:**
   - Jump to 32'hFFFF_FFFF, then select 00 → `pc`=0.
   - `en`=0 for 3 cycles → `pc` holds at 0.
   - `pc_next` reads 1 throughout.
3. **Call/return:**
   - At `pc`=0x10, call to `in_JMP`=0x100 → `pc`=0x100.
   - At 0x100, call to `in_ALU`=0x200 → `pc`=0x200.
   - Two returns → `pc`=0x101, then 0x11. `ras_empty`=1 after the second return.
4. **Overflow:**
   - Five consecutive calls from `pc`=0, 0x10, 0x20, 0x30, 0x40 → `ras_full`=1.
   - Five returns → 0x41, 0x31, 0x21, 0x11, then fall-through to 0x12.
   - `ras_underflow`=1 after the fifth return.
5. **Underflow sticky:** return on an empty stack at `pc`=0x50 → `pc`=0x51 and `ras_underflow`=1. It stays 1 across later calls and is cleared only by `rst_n`=0.
6. **Ignored call / stall with call:**
   - `call`=1 with select 00 → no push, `ras_empty` stays 1.
   - `call`=1 with select 10 and `en`=0 → no push, `pc` unchanged.
